// File: rtl/soc_clk_pkg.sv
// rtl/soc_clk_pkg.sv - shared cfg bit positions, channel limit and reset-state type
package soc_clk_pkg;
  localparam int MAX_CH   = 16;
  localparam int DIV_LSB  = 0;
  localparam int EN_BIT   = 16;
  localparam int SRST_BIT = 17;
  localparam int BUSY_BIT = 17;
  localparam int PEND_BIT = 18;

  typedef enum logic [1:0] {HOLD, WAIT, RUN} rst_state_e;
endpackage

// File: rtl/soc_clk_div_ch.sv
// rtl/soc_clk_div_ch.sv - one clock-enable divider with its HOLD/WAIT/RUN reset sequencer
module soc_clk_div_ch
  import soc_clk_pkg::*;
#(
  parameter int DIV_W   = 8,
  parameter int RST_DLY = 4,
  parameter int RST_DIV = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_i,
  input  logic [DIV_W-1:0] wr_div_i,
  input  logic             wr_en_i,
  input  logic             wr_srst_i,
  input  logic             pred_done_i,
  output logic             pulse_o,
  output logic             run_o,
  output logic             done_set_o,
  output logic [DIV_W-1:0] div_o,
  output logic             en_o,
  output logic             pend_o
);
  localparam int DLY_W = (RST_DLY > 1) ? $clog2(RST_DLY) : 1;
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(RST_DLY - 1);

  rst_state_e       state_q, state_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [DIV_W-1:0] div_q, div_d, stage_q, stage_d, cnt_q, cnt_d;
  logic             pend_q, pend_d, en_q, en_d;
  logic             tick, pulse, last_pulse;

  assign tick       = (div_q < DIV_W'(2)) || (cnt_q == div_q - DIV_W'(1));
  assign pulse      = en_q && tick;
  assign last_pulse = (state_q == WAIT) && pulse && (dly_q == DLY_LAST);

  // Independent of pred_done_i so the done chain across channels has no loop
  assign done_set_o = ((state_q == RUN) || last_pulse) && !(wr_i && wr_srst_i);
  assign pulse_o    = pulse;
  assign run_o      = (state_q == RUN);
  assign div_o      = div_q;
  assign en_o       = en_q;
  assign pend_o     = pend_q;

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    div_d   = div_q;
    stage_d = stage_q;
    pend_d  = pend_q;
    en_d    = en_q;
    cnt_d   = (!en_q || tick) ? '0 : cnt_q + DIV_W'(1);
    if (pend_q && tick) begin
      div_d  = stage_q;
      pend_d = 1'b0;
    end
    case (state_q)
      HOLD:    if (en_q && pred_done_i) begin
                 state_d = WAIT;
                 dly_d   = '0;
               end
      WAIT:    if (last_pulse) state_d = RUN;
               else if (pulse) dly_d = dly_q + DLY_W'(1);
      default: ;
    endcase
    if (wr_i) begin
      en_d = wr_en_i;
      if (wr_srst_i) begin
        state_d = HOLD;
        dly_d   = '0;
      end
      // A channel not producing pulses has no period to protect
      if (wr_srst_i || state_q == HOLD || !en_q || !wr_en_i) begin
        div_d  = wr_div_i;
        cnt_d  = '0;
        pend_d = 1'b0;
      end else begin
        stage_d = wr_div_i;
        pend_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= HOLD;
      dly_q   <= '0;
      div_q   <= DIV_W'(RST_DIV);
      stage_q <= DIV_W'(RST_DIV);
      pend_q  <= 1'b0;
      en_q    <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      div_q   <= div_d;
      stage_q <= stage_d;
      pend_q  <= pend_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: rtl/soc_clk_div_rst_seq.sv
// rtl/soc_clk_div_rst_seq.sv - NUM_CH clock-enable dividers with ordered reset release and req/ack config
// Optional SOC_CLK_DIV_TEST_BYPASS_EN adds test_mode_i forcing enables high and resets to rst_ni.
module soc_clk_div_rst_seq
  import soc_clk_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int DIV_W   = 8,
  parameter int RST_DLY = 4,
  parameter int RST_DIV = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
`ifdef SOC_CLK_DIV_TEST_BYPASS_EN
  input  logic              test_mode_i,
`endif
  input  logic              cfg_req_i,
  input  logic              cfg_wrn_i,
  input  logic [3:0]        cfg_add_i,
  input  logic [31:0]       cfg_data_i,
  output logic              cfg_ack_o,
  output logic [31:0]       cfg_r_data_o,
  output logic [NUM_CH-1:0] clk_en_o,
  output logic [NUM_CH-1:0] rstn_o,
  output logic              seq_done_o
);
  logic              ack_q, seq_done_q, accept;
  logic [31:0]       rdata_q, rd_word;
  logic [NUM_CH-1:0] done_q, done_d, pred_done, wr;
  logic [NUM_CH-1:0] ch_pulse, ch_run, ch_done_set, ch_en, ch_pend;
  logic [DIV_W-1:0]  ch_div [NUM_CH];
  logic              unused_data;

  assign accept      = cfg_req_i && !ack_q;
  assign unused_data = ^cfg_data_i;
  assign done_d      = done_q | ch_done_set;

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      assign wr[g] = accept && !cfg_wrn_i && (cfg_add_i == 4'(g));
      if (g == 0) begin : g_first
        assign pred_done[g] = 1'b1;
      end else begin : g_rest
        assign pred_done[g] = done_d[g-1];
      end
      soc_clk_div_ch #(.DIV_W(DIV_W), .RST_DLY(RST_DLY), .RST_DIV(RST_DIV)) u_ch (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .wr_i       (wr[g]),
        .wr_div_i   (cfg_data_i[DIV_LSB +: DIV_W]),
        .wr_en_i    (cfg_data_i[EN_BIT]),
        .wr_srst_i  (cfg_data_i[SRST_BIT]),
        .pred_done_i(pred_done[g]),
        .pulse_o    (ch_pulse[g]),
        .run_o      (ch_run[g]),
        .done_set_o (ch_done_set[g]),
        .div_o      (ch_div[g]),
        .en_o       (ch_en[g]),
        .pend_o     (ch_pend[g])
      );
    end
  endgenerate

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_add_i == 4'(i)) begin
        rd_word[DIV_LSB +: DIV_W] = ch_div[i];
        rd_word[EN_BIT]           = ch_en[i];
        rd_word[BUSY_BIT]         = !ch_run[i];
        rd_word[PEND_BIT]         = ch_pend[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ack_q      <= 1'b0;
      rdata_q    <= '0;
      done_q     <= '0;
      seq_done_q <= 1'b0;
    end else begin
      ack_q      <= accept;
      rdata_q    <= (accept && cfg_wrn_i) ? rd_word : '0;
      done_q     <= done_d;
      seq_done_q <= &done_q;
    end
  end

  assign cfg_ack_o    = ack_q;
  assign cfg_r_data_o = rdata_q;
  assign seq_done_o   = seq_done_q;

`ifdef SOC_CLK_DIV_TEST_BYPASS_EN
  assign clk_en_o = test_mode_i ? {NUM_CH{1'b1}} : (ch_pulse & {NUM_CH{rst_ni}});
  assign rstn_o   = test_mode_i ? {NUM_CH{rst_ni}} : ch_run;
`else
  assign clk_en_o = ch_pulse & {NUM_CH{rst_ni}};
  assign rstn_o   = ch_run;
`endif
endmodule

// File: tb/tb_soc_clk_div_rst_seq.sv
// tb/tb_soc_clk_div_rst_seq.sv - scoreboard bench: cfg responses queued at issue, checked on every ack
module tb_soc_clk_div_rst_seq;
  localparam int NUM_CH = 3;

  logic              clk = 1'b0;
  logic              rst_ni = 1'b0;
  logic              test_mode = 1'b0;
  logic              cfg_req = 1'b0, cfg_wrn = 1'b0;
  logic [3:0]        cfg_add = '0;
  logic [31:0]       cfg_data = '0;
  logic              cfg_ack_o, seq_done_o;
  logic [31:0]       cfg_r_data_o;
  logic [NUM_CH-1:0] clk_en_o, rstn_o;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  soc_clk_div_rst_seq #(.NUM_CH(NUM_CH), .DIV_W(8), .RST_DLY(4), .RST_DIV(1)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
`ifdef SOC_CLK_DIV_TEST_BYPASS_EN
    .test_mode_i (test_mode),
`endif
    .cfg_req_i   (cfg_req),
    .cfg_wrn_i   (cfg_wrn),
    .cfg_add_i   (cfg_add),
    .cfg_data_i  (cfg_data),
    .cfg_ack_o   (cfg_ack_o),
    .cfg_r_data_o(cfg_r_data_o),
    .clk_en_o    (clk_en_o),
    .rstn_o      (rstn_o),
    .seq_done_o  (seq_done_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (cfg_ack_o === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL ack_unexpected: ack with nothing pending, rdata 0x%0h", cfg_r_data_o);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (cfg_r_data_o === e) n_pass++;
        else $display("FAIL cfg_rdata: got 0x%0h expected 0x%0h", cfg_r_data_o, e);
      end
    end
  end

  task automatic cfg_op(input logic wrn, input logic [3:0] add, input logic [31:0] data,
                        input logic [31:0] exp);
    int t;
    exp_q.push_back(exp);
    cfg_req = 1'b1; cfg_wrn = wrn; cfg_add = add; cfg_data = data;
    t = 0;
    do begin
      @(negedge clk); t++;
    end while (cfg_ack_o !== 1'b1 && t < 20);
    if (cfg_ack_o !== 1'b1) begin
      n_checks++;
      $display("FAIL cfg_timeout: no ack after %0d cycles, required ack within 20", t);
    end
    cfg_req = 1'b0;
  endtask

  task automatic count_until(input int sel, input int ch, output int n);
    logic hit;
    n = 0;
    do begin
      @(negedge clk); n++;
      case (sel)
        0:       hit = clk_en_o[ch];
        1:       hit = rstn_o[ch];
        default: hit = seq_done_o;
      endcase
    end while (!hit && n < 60);
  endtask

  initial begin
    int n, acks, pulses;
    cfg_req = 1'b1; cfg_wrn = 1'b0; cfg_add = 4'd0; cfg_data = 32'h0002_0000;
    repeat (3) @(negedge clk);
    check("rst_ack", {31'd0, cfg_ack_o}, 32'd0);
    check("rst_rdata", cfg_r_data_o, 32'd0);
    check("rst_clk_en", {29'd0, clk_en_o}, 32'd0);
    check("rst_rstn", {29'd0, rstn_o}, 32'd0);
    check("rst_seq_done", {31'd0, seq_done_o}, 32'd0);
    cfg_req = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;

    count_until(1, 0, n); check("rstn0_delay", 32'(n), 32'd5);
    count_until(1, 1, n); check("rstn1_delay", 32'(n), 32'd4);
    count_until(1, 2, n); check("rstn2_delay", 32'(n), 32'd4);
    count_until(2, 0, n); check("seq_done_delay", 32'(n), 32'd1);

    cfg_op(1'b1, 4'd0, 32'd0, 32'h0001_0001);
    cfg_op(1'b1, 4'd1, 32'd0, 32'h0001_0001);
    cfg_op(1'b1, 4'd2, 32'd0, 32'h0001_0001);

    cfg_op(1'b0, 4'd1, 32'h0001_0008, 32'd0);
    count_until(0, 1, n); check("ch1_div8_first", 32'(n), 32'd8);
    cfg_op(1'b0, 4'd1, 32'h0001_0004, 32'd0);
    cfg_op(1'b1, 4'd1, 32'd0, 32'h0005_0008);
    count_until(0, 1, n); check("ch1_period_done", 32'(n), 32'd5);
    count_until(0, 1, n); check("ch1_div4_gap_a", 32'(n), 32'd4);
    count_until(0, 1, n); check("ch1_div4_gap_b", 32'(n), 32'd4);
    cfg_op(1'b1, 4'd1, 32'd0, 32'h0001_0004);

    cfg_op(1'b0, 4'd2, 32'h0001_0003, 32'd0);
    cfg_op(1'b0, 4'd2, 32'h0000_0003, 32'd0);
    check("ch2_dis_clk_en", {31'd0, clk_en_o[2]}, 32'd0);
    check("ch2_dis_rstn", {31'd0, rstn_o[2]}, 32'd1);
    cfg_op(1'b1, 4'd2, 32'd0, 32'h0000_0003);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pulses += int'(clk_en_o[2]);
    end
    check("ch2_dis_quiet", 32'(pulses), 32'd0);
    cfg_op(1'b0, 4'd2, 32'h0001_0003, 32'd0);
    check("ch2_reen_ack_cycle", {31'd0, clk_en_o[2]}, 32'd0);
    count_until(0, 2, n); check("ch2_reen_first", 32'(n), 32'd2);
    count_until(0, 2, n); check("ch2_reen_gap", 32'(n), 32'd3);

    for (int k = 0; k < 2; k++) begin
      repeat (3) exp_q.push_back(32'd0);
      cfg_req = 1'b1; cfg_wrn = (k == 1); cfg_add = 4'd5; cfg_data = 32'h0002_0000;
      acks = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        acks += int'(cfg_ack_o);
      end
      cfg_req = 1'b0;
      check(k == 0 ? "oob_write_acks" : "oob_read_acks", 32'(acks), 32'd3);
    end
    cfg_op(1'b1, 4'd0, 32'd0, 32'h0001_0001);
    cfg_op(1'b1, 4'd1, 32'd0, 32'h0001_0004);
    cfg_op(1'b1, 4'd2, 32'd0, 32'h0001_0003);
    check("oob_rstn", {29'd0, rstn_o}, 32'd7);

    cfg_op(1'b0, 4'd0, 32'h0003_0001, 32'd0);
    check("srst_rstn0", {31'd0, rstn_o[0]}, 32'd0);
    check("srst_rstn_hi", {30'd0, rstn_o[2:1]}, 32'd3);
    check("srst_seq_done", {31'd0, seq_done_o}, 32'd1);
    count_until(1, 0, n); check("srst_release", 32'(n), 32'd5);
    check("srst_rstn_all", {29'd0, rstn_o}, 32'd7);
    check("srst_seq_done_after", {31'd0, seq_done_o}, 32'd1);
    cfg_op(1'b1, 4'd0, 32'd0, 32'h0001_0001);

    cfg_req = 1'b1; cfg_wrn = 1'b1; cfg_add = 4'd0; rst_ni = 1'b0;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      acks += int'(cfg_ack_o);
    end
    check("mid_rst_no_ack", 32'(acks), 32'd0);
    check("mid_rst_rstn", {29'd0, rstn_o}, 32'd0);
    cfg_req = 1'b0;

`ifdef SOC_CLK_DIV_TEST_BYPASS_EN
    rst_ni = 1'b1; test_mode = 1'b1;
    repeat (2) @(negedge clk);
    check("byp_clk_en", {29'd0, clk_en_o}, 32'd7);
    check("byp_rstn", {29'd0, rstn_o}, 32'd7);
    test_mode = 1'b0;
    #1;
    check("byp_exit_rstn", {29'd0, rstn_o}, 32'd0);
    count_until(1, 0, n); check("byp_resume_rstn0", 32'(n), 32'd3);
`endif

    repeat (2) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/soc_clk_div_rst_seq.md
Name: soc_clk_div_rst_seq

Overview:
- Parametrised successor of the SoC clock/reset generator.
- Takes one root clock and derives NUM_CH clock-enable channels, each with a programmable integer divider, for use with downstream ICGs.
- Produces a per-channel synchronised reset, released in channel order after a programmable settle delay.
- Configured over the same req/ack slave handshake the FLL config ports use; sits between the FLL clock mux and the SoC/peripheral/cluster domains.

Parameters:
- NUM_CH, 3, number of derived channels (1..16).
- DIV_W, 8, divider field width in bits.
- RST_DLY, 4, number of channel enable pulses between reset-hold exit and reset release.
- RST_DIV, 1, divider value loaded into every channel at reset.

Ports:
- clk_i  in  1  root clock.
- rst_ni  in  1  synchronous active-low reset.
- cfg_req_i  in  1  config request; held until cfg_ack_o.
- cfg_wrn_i  in  1  1 = read, 0 = write.
- cfg_add_i  in  4  channel index.
- cfg_data_i  in  32  write data.
- cfg_ack_o  out  1  one-cycle acknowledge.
- cfg_r_data_o  out  32  read data, valid while cfg_ack_o = 1.
- clk_en_o  out  NUM_CH  per-channel clock enable.
- rstn_o  out  NUM_CH  per-channel active-low reset, synchronous to clk_i.
- seq_done_o  out  1  all channels reached RUN at least once.

Behaviour:
- Reset: one clock, clk_i; reset is synchronous and active-low (rst_ni sampled on the rising edge of clk_i).
- Values while rst_ni = 0:
  - cfg_ack_o = 0, cfg_r_data_o = 0, clk_en_o = 0, rstn_o = 0, seq_done_o = 0.
  - div = RST_DIV, enable = 1 for every channel; all FSMs in HOLD; counters = 0.
- Write data format: data[DIV_W-1:0] = div, data[16] = enable, data[17] = soft reset (self-clearing).
- Read data format: [DIV_W-1:0] = active div, [16] = enable, [17] = 1 while channel not in RUN, [18] = staged div pending. Other bits 0.
- Handshake:
  - A request is accepted when cfg_req_i = 1 and cfg_ack_o = 0.
  - cfg_ack_o asserts the next cycle for exactly one cycle; the write takes effect in that cycle.
  - A held req therefore acks every second cycle.
  - cfg_add_i >= NUM_CH: write ignored, read returns 0, still acked.
- Divider:
  - Per-channel counter of width DIV_W.
  - div = 0 or 1: clk_en_o = enable, every cycle.
  - div = d >= 2: clk_en_o pulses for one cycle when the counter reaches d-1, then the counter wraps to 0, giving period d.
  - A new div is staged and applied at the cycle after the wrap, so there is no partial period.
  - If the channel is disabled or in HOLD, the new div applies immediately and the counter clears.
  - enable = 0: clk_en_o = 0 and the counter holds 0.
- Reset FSM per channel (HOLD -> WAIT -> RUN):
  - HOLD: rstn_o = 0. Exit when the channel is enabled and the predecessor's sticky done flag is set (channel 0: no predecessor).
  - WAIT: rstn_o = 0. Counts RST_DLY clk_en_o pulses, then moves to RUN.
  - RUN: rstn_o = 1; the sticky done flag is set.
  - Soft reset in any state: to HOLD, this channel only. Higher channels stay unaffected because their predecessor's done flag is sticky.
  - Disabling a channel in WAIT freezes the count; re-enabling resumes it.
- seq_done_o = AND of all sticky done flags. Registered, so it rises one cycle after the last flag is set.
- Simultaneous soft reset and div write in one transaction: div applies immediately because the channel is in HOLD.
- Reset asserted mid-transaction: ack suppressed; the pending request is dropped.

Optional Feature:
- Macro: SOC_CLK_DIV_TEST_BYPASS_EN.
- Defined:
  - Adds port test_mode_i (in, 1).
  - When test_mode_i = 1: clk_en_o = all ones, rstn_o = {NUM_CH{rst_ni}}, cfg writes still update registers.
  - Returning to 0 resumes from the stored state.
- Undefined: no port; behaviour as above.

Decomposition:
- Shared package soc_clk_pkg:
  - cfg data bit positions (DIV_LSB, EN_BIT, SRST_BIT, BUSY_BIT, PEND_BIT);
  - typedef rst_state_e {HOLD, WAIT, RUN};
  - max channel count constant.
- Sub-module soc_clk_div_ch: one divider plus reset FSM, instantiated NUM_CH times via generate.
- The top level holds the cfg decode and the done-flag chain.

Test Plan:
- Reset release, defaults (NUM_CH = 3, RST_DIV = 1, RST_DLY = 4) -> rstn_o[0] high 5 cycles after rst_ni rises; rstn_o[1] 4 cycles later; rstn_o[2] 4 after that; seq_done_o 1 cycle after rstn_o[2].
- Write ch1 div = 4 while running -> current period completes; then clk_en_o[1] pulses every 4 cycles; read-back bit18 = 1 until applied, then 0.
- Soft reset ch0 after seq_done -> rstn_o[0] = 0 for 4 enable pulses; rstn_o[1..2] stay 1; seq_done_o stays 1.
- Write enable = 0 to ch2 -> clk_en_o[2] = 0 next cycle; read bit16 = 0; re-enable resumes the period from counter 0.
- Held cfg_req_i with cfg_add_i = 5 -> cfg_ack_o every second cycle; cfg_r_data_o = 0; no register changes.
- With SOC_CLK_DIV_TEST_BYPASS_EN, test_mode_i = 1 during HOLD -> clk_en_o = 3'b111, rstn_o = 3'b111; deassert -> rstn_o = 0 again and the sequence restarts from stored state.
